data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed data memory for the processor's load/store path.
- Converts byte addresses to word indices and supports word and byte accesses over a request/response handshake.
- Byte stores use an internal read-modify-write sequence.
- Misaligned or out-of-range accesses are flagged instead of silently aliasing.

Parameters:
DATA_W, 16, word width in bits; multiple of 8, at least 16
ADDR_W, 16, byte-address width
DEPTH, 1024, number of words in the array; power of two
LANES (derived), DATA_W/8, bytes per word
SHIFT (derived), $clog2(LANES), byte-offset bits stripped from the address

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  1  0 = byte, 1 = word
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data; byte stores use bits [7:0]
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  load data; byte loads zero-extended; 0 on stores and errors
rsp_err  out  1  access rejected (misaligned or out of range)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Any in-flight operation is abandoned; the array is left unmodified by the aborted operation.
  - Array contents are not cleared unless the optional feature is enabled.
- Handshake:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready is high only in IDLE.
  - Responses have no backpressure; rsp_valid is high for exactly one cycle per accepted request.
- Address decoding:
  - word index = req_addr >> SHIFT.
  - lane = req_addr[SHIFT-1:0].
  - Error if req_size = 1 and lane != 0 (misaligned).
  - Error if word index >= DEPTH (out of range).
  - On error: no array access; rsp_err = 1 and rsp_rdata = 0 on the cycle after acceptance.
- FSM states: IDLE, RESP, RMW_RD, RMW_WR (plus CLEAR with the optional feature).
  - IDLE, accepting a load, word store, or erroring request -> RESP.
    - A word store writes the array on the acceptance edge.
    - A load reads the array synchronously.
    - RESP drives rsp_valid = 1 with registered data, then returns to IDLE. Latency is 1 cycle; throughput is 1 request per 2 cycles.
  - IDLE, accepting a valid byte store -> RMW_RD.
    - Latch index, lane, and wdata[7:0].
    - RMW_RD: read word -> RMW_WR.
    - RMW_WR: write the word with only byte lane `lane` replaced -> RESP, giving rsp_valid 3 cycles after acceptance.
- Byte load: rsp_rdata = {zeros, word[8*lane+7 : 8*lane]}.
- Request inputs are ignored while req_ready = 0.
- Mid-operation reset: a reset asserted during RMW_RD or RMW_WR suppresses the pending write.
- Read-after-write: a load issued the request after a store to the same word returns the new data. No bypass is needed because the store completes before IDLE.
- Memory is inferred as a synchronous-write, registered-read array of DEPTH x DATA_W.

Optional Feature:
- Macro: DATA_MEM_CLEAR_EN.
- Defined:
  - After rst_n is released, the FSM enters CLEAR with req_ready = 0.
  - A counter writes 0 to words 0..DEPTH-1, one per cycle, then goes to IDLE. Clearing takes DEPTH cycles.
  - Reset during CLEAR restarts clearing from word 0.
- Not defined:
  - The CLEAR state and counter are absent and the FSM leaves reset directly in IDLE.
  - Array contents after power-up are undefined.

Test Plan:
- Word store then load (DATA_W=16): store addr 0x0010, data 0xBEEF; load addr 0x0010 -> rsp_rdata = 0xBEEF, rsp_err = 0, rsp_valid 1 cycle after load acceptance.
- Byte store merge: word at 0x0020 = 0x1234; byte store addr 0x0021, data 0x00AB -> rsp_valid 3 cycles after acceptance; word load of 0x0020 = 0xAB34; byte load of 0x0020 = 0x0034.
- Misaligned word load at 0x0003 -> rsp_err = 1, rsp_rdata = 0, array unchanged, req_ready back high 2 cycles after acceptance.
- Out-of-range access: store to byte addr 2*DEPTH (0x0800) -> rsp_err = 1; word 0 (the aliasing candidate) still reads its prior value.
- Reset mid-RMW: word 0x0040 = 0x5555; byte store 0x0040 data 0x00AA; assert rst_n = 0 in RMW_WR -> outputs return to reset values next edge, and a later read of 0x0040 = 0x5555.
- DATA_MEM_CLEAR_EN: after reset, req_ready stays 0 for DEPTH cycles; a load of the last word (0x07FE) returns 0x0000.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with word/byte load-store over a valid/ready handshake.
// Optional power-up clearing of the array is enabled by defining DATA_MEM_CLEAR_EN.
module data_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int LANES = DATA_W / 8;
  localparam int SHIFT = $clog2(LANES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic [2:0] {IDLE, RESP, RMW_RD, RMW_WR, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [2:0] {IDLE, RESP, RMW_RD, RMW_WR} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state_reg, state_next;

  // Request decode
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  req_idx;
  logic [SHIFT-1:0]  req_lane;
  logic              misaligned, out_of_range, req_err, accept;

  assign word_idx     = req_addr >> SHIFT;
  assign req_idx      = IDX_W'(word_idx);
  assign req_lane     = req_addr[SHIFT-1:0];
  assign misaligned   = req_size && (req_lane != '0);
  assign out_of_range = 64'(word_idx) >= 64'(DEPTH);
  assign req_err      = misaligned || out_of_range;
  assign accept       = rst_n && req_valid && (state_reg == IDLE);

  // Latched request context
  logic [IDX_W-1:0] idx_reg;
  logic [SHIFT-1:0] lane_reg;
  logic [7:0]       byte_reg;
  logic             err_reg, we_reg, size_reg;

  // Array port
  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_rd_en, mem_wr_en;
  logic [IDX_W-1:0]  mem_rd_idx, mem_wr_idx;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

`ifdef DATA_MEM_CLEAR_EN
  logic [IDX_W-1:0] clr_reg, clr_next;
`endif

  // Lane merge for byte stores and lane select for byte loads
  logic [DATA_W-1:0] merged_word;
  logic [7:0]        lane_bytes [LANES];
  logic [DATA_W-1:0] byte_ext;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = (lane_reg == SHIFT'(gi)) ? byte_reg : mem_rd_data[8*gi +: 8];
      assign lane_bytes[gi]         = mem_rd_data[8*gi +: 8];
    end
  endgenerate

  assign byte_ext = {{(DATA_W-8){1'b0}}, lane_bytes[lane_reg]};

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_rd_en   = 1'b0;
    mem_rd_idx  = req_idx;
    mem_wr_en   = 1'b0;
    mem_wr_idx  = req_idx;
    mem_wr_data = req_wdata;
`ifdef DATA_MEM_CLEAR_EN
    clr_next    = clr_reg;
`endif
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && !req_size) begin
            state_next = RMW_RD;
          end else begin
            state_next = RESP;
            mem_wr_en  = req_we;
            mem_rd_en  = !req_we;
          end
        end
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_reg;
        if (!err_reg && !we_reg) begin
          rsp_rdata = size_reg ? mem_rd_data : byte_ext;
        end
        state_next = IDLE;
      end
      RMW_RD: begin
        mem_rd_en  = 1'b1;
        mem_rd_idx = idx_reg;
        state_next = RMW_WR;
      end
      RMW_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_idx  = idx_reg;
        mem_wr_data = merged_word;
        state_next  = RESP;
      end
`ifdef DATA_MEM_CLEAR_EN
      CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_wr_idx  = clr_reg;
        mem_wr_data = '0;
        clr_next    = clr_reg + 1'b1;
        if (clr_reg == IDX_W'(DEPTH - 1)) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    // A reset edge must never commit a pending write
    if (!rst_n) begin
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      idx_reg   <= '0;
      lane_reg  <= '0;
      byte_reg  <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      size_reg  <= 1'b0;
`ifdef DATA_MEM_CLEAR_EN
      clr_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
`ifdef DATA_MEM_CLEAR_EN
      clr_reg   <= clr_next;
`endif
      if (accept) begin
        idx_reg  <= req_idx;
        lane_reg <= req_lane;
        byte_reg <= req_wdata[7:0];
        err_reg  <= req_err;
        we_reg   <= req_we;
        size_reg <= req_size;
      end
    end
  end

  // Plain array with registered read so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_idx] <= mem_wr_data;
    end
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_idx];
    end
  end

endmodule
